axi_llc_cfg_seq: RTL and testbench
==================================

AXI_LLC_CFG_SEQ -- requirements
Module: axi_llc_cfg_seq

Interface
- REQ-001: Parameter NumWays, default 8, number of LLC ways; legal range 1..32.
- REQ-002: Parameter BaseAddr, default 32'h0, RegBus base address of the LLC configuration registers.
- REQ-003: Parameters OffSpm / OffFlush / OffCommit / OffFlushed, defaults 32'h00 / 32'h08 / 32'h10 / 32'h18, register offsets from BaseAddr.
- REQ-004: Parameter PollGap, default 16, idle cycles between two status reads; legal range 1..255.
- REQ-005: Parameter PollMax, default 1024, maximum status reads before timeout; legal range 1..65535.
- REQ-006: clk_i  in  1  single clock; all state changes on its rising edge.
- REQ-007: rst_i  in  1  asynchronous, active-high reset.
- REQ-008: start_i  in  1  request one configuration sequence; sampled only in IDLE.
- REQ-009: spm_mask_i  in  NumWays  ways to switch to SPM; captured at accepted start.
- REQ-010: flush_mask_i  in  NumWays  ways to flush; captured at accepted start.
- REQ-011: busy_o  out  1  high in every state except IDLE.
- REQ-012: done_o  out  1  one-cycle pulse on successful completion.
- REQ-013: err_o  out  1  one-cycle pulse on failed completion.
- REQ-014: err_code_o  out  2  cause of the failure; 1 = bus error, 2 = poll timeout; holds until the next accepted start.
- REQ-015: reg_addr_o / reg_write_o / reg_wdata_o / reg_wstrb_o / reg_valid_o  out  32/1/32/4/1  RegBus request to the LLC configuration port.
- REQ-016: reg_rdata_i / reg_error_i / reg_ready_i  in  32/1/1  RegBus response.

Function
- REQ-017: FSM states: IDLE, WR_SPM, WR_FLUSH, WR_COMMIT, RD_STAT, GAP, FIN.
- REQ-018: In IDLE, start_i=1 captures both masks, clears err_code_o and the poll counter, and moves to WR_SPM on the next edge.
- REQ-019: A RegBus transfer completes in the cycle in which reg_valid_o and reg_ready_i are both high.
- REQ-020: reg_valid_o is high in WR_*/RD_STAT; address, write, wdata and wstrb stay stable until the transfer completes.
- REQ-021: WR_SPM writes BaseAddr+OffSpm, data = zero-extended spm mask, wstrb 4'hF.
- REQ-022: After WR_SPM, go to WR_FLUSH if the flush mask is nonzero, else go to WR_COMMIT.
- REQ-023: WR_FLUSH writes BaseAddr+OffFlush, data = zero-extended flush mask, then goes to WR_COMMIT.
- REQ-024: WR_COMMIT writes BaseAddr+OffCommit, data 32'h1.
- REQ-025: After WR_COMMIT, go to RD_STAT if the flush mask is nonzero, else go to FIN with success.
- REQ-026: RD_STAT reads BaseAddr+OffFlushed (reg_write_o=0, wdata 0, wstrb 0) and increments the 16-bit poll counter on completion.
- REQ-027: Status check: if (reg_rdata_i[NumWays-1:0] & flush mask) == flush mask, go to FIN with success.
- REQ-028: Otherwise, if poll counter == PollMax, go to FIN with err_code 2.
- REQ-029: Otherwise go to GAP, wait exactly PollGap cycles with reg_valid_o=0, then return to RD_STAT.
- REQ-030: reg_error_i=1 on any completed transfer aborts immediately to FIN with err_code 1; later steps are not issued.
- REQ-031: FIN lasts one cycle, pulses done_o or err_o (never both), then returns to IDLE.
- REQ-032: start_i is ignored while busy_o=1.
- REQ-033: No combinational path exists from reg_ready_i, reg_rdata_i or reg_error_i to reg_valid_o; all outputs are registered or decoded from state.
- REQ-034: Minimum sequence latency with ready always high and both masks zero: start to done_o = 4 cycles (WR_SPM, WR_COMMIT, FIN, plus capture edge).

Reset
- REQ-035: rst_i=1 forces IDLE asynchronously, including mid-transfer; the transfer is dropped and not retried.
- REQ-036: Under rst_i=1: reg_valid_o=0, busy_o=0, done_o=0, err_o=0, err_code_o=0, poll counter 0, captured masks 0; all other request outputs 0.

Verification
- REQ-037: Masks zero, ready tied high, start -> two writes: 0x00 = 0, then 0x10 = 1; done_o at cycle 4; no reads issued.
- REQ-038: spm 8'h0F, flush 8'hF0, ready delayed 3 cycles per transfer -> request signals stable while waiting; writes 0x00 = 0x0F, 0x08 = 0xF0, 0x10 = 1; reads continue until rdata 0xF0, then done_o.
- REQ-039: Status read returns 0x70 forever, PollMax=4 -> exactly 4 reads, each separated by PollGap idle cycles; err_o pulse with err_code_o=2.
- REQ-040: reg_error_i=1 on the WR_FLUSH transfer -> err_o with err_code_o=1; no commit write is issued.
- REQ-041: rst_i asserted during GAP with reg_valid_o held -> all outputs are reset immediately; a new start then runs a full sequence correctly.
- REQ-042: start_i toggled while busy -> no effect on the sequence, and exactly one done_o is produced.

Source files
------------

// File: rtl/axi_llc_cfg_seq.sv
// LLC configuration sequencer: writes the SPM and flush way masks over RegBus, commits
// them, then polls the flushed-status register until the requested ways are flushed.
module axi_llc_cfg_seq #(
    parameter int unsigned NumWays    = 8,
    parameter logic [31:0] BaseAddr   = 32'h0,
    parameter logic [31:0] OffSpm     = 32'h00,
    parameter logic [31:0] OffFlush   = 32'h08,
    parameter logic [31:0] OffCommit  = 32'h10,
    parameter logic [31:0] OffFlushed = 32'h18,
    parameter int unsigned PollGap    = 16,
    parameter int unsigned PollMax    = 1024
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [NumWays-1:0] spm_mask_i,
    input  logic [NumWays-1:0] flush_mask_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [1:0]         err_code_o,
    output logic [31:0]        reg_addr_o,
    output logic               reg_write_o,
    output logic [31:0]        reg_wdata_o,
    output logic [3:0]         reg_wstrb_o,
    output logic               reg_valid_o,
    input  logic [31:0]        reg_rdata_i,
    input  logic               reg_error_i,
    input  logic               reg_ready_i
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WR_SPM    = 3'd1;
    localparam logic [2:0] WR_FLUSH  = 3'd2;
    localparam logic [2:0] WR_COMMIT = 3'd3;
    localparam logic [2:0] RD_STAT   = 3'd4;
    localparam logic [2:0] GAP       = 3'd5;
    localparam logic [2:0] FIN       = 3'd6;

    localparam logic [1:0]  ERR_BUS     = 2'd1;
    localparam logic [1:0]  ERR_TIMEOUT = 2'd2;
    localparam logic [15:0] POLL_MAX_W  = 16'(PollMax);
    localparam logic [7:0]  GAP_LOAD    = 8'(PollGap - 1);

    logic [2:0]         state;
    logic [NumWays-1:0] spm_q;
    logic [NumWays-1:0] flush_q;
    logic [15:0]        poll_cnt;
    logic [7:0]         gap_cnt;
    logic               fin_err;

    logic [31:0] spm_ext;
    logic [31:0] flush_ext;
    logic        xfer_done;
    logic        status_ok;
    logic        flush_any;
    logic [15:0] poll_inc;
    logic        unused_rdata;

    assign unused_rdata = ^reg_rdata_i;

    always_comb begin
        spm_ext                  = '0;
        flush_ext                = '0;
        spm_ext[NumWays-1:0]     = spm_q;
        flush_ext[NumWays-1:0]   = flush_q;
    end

    assign xfer_done = reg_valid_o & reg_ready_i;
    assign status_ok = (reg_rdata_i[NumWays-1:0] & flush_q) == flush_q;
    assign flush_any = |flush_q;
    assign poll_inc  = poll_cnt + 16'd1;

    assign busy_o = (state != IDLE);
    assign done_o = (state == FIN) & ~fin_err;
    assign err_o  = (state == FIN) &  fin_err;

    // Request fields are a pure decode of state and the captured masks, so they
    // hold steady while a slave stalls and never depend on the response inputs.
    always_comb begin
        reg_valid_o = 1'b0;
        reg_write_o = 1'b0;
        reg_addr_o  = '0;
        reg_wdata_o = '0;
        reg_wstrb_o = '0;
        case (state)
            WR_SPM: begin
                reg_valid_o = 1'b1;
                reg_write_o = 1'b1;
                reg_addr_o  = BaseAddr + OffSpm;
                reg_wdata_o = spm_ext;
                reg_wstrb_o = 4'hF;
            end
            WR_FLUSH: begin
                reg_valid_o = 1'b1;
                reg_write_o = 1'b1;
                reg_addr_o  = BaseAddr + OffFlush;
                reg_wdata_o = flush_ext;
                reg_wstrb_o = 4'hF;
            end
            WR_COMMIT: begin
                reg_valid_o = 1'b1;
                reg_write_o = 1'b1;
                reg_addr_o  = BaseAddr + OffCommit;
                reg_wdata_o = 32'h1;
                reg_wstrb_o = 4'hF;
            end
            RD_STAT: begin
                reg_valid_o = 1'b1;
                reg_addr_o  = BaseAddr + OffFlushed;
            end
            default: ;
        endcase
    end

    // Sequence control; a bus error on any completed transfer aborts straight to FIN.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            spm_q      <= '0;
            flush_q    <= '0;
            poll_cnt   <= '0;
            gap_cnt    <= '0;
            fin_err    <= 1'b0;
            err_code_o <= 2'd0;
        end else begin
            case (state)
                IDLE: if (start_i) begin
                    spm_q      <= spm_mask_i;
                    flush_q    <= flush_mask_i;
                    poll_cnt   <= '0;
                    fin_err    <= 1'b0;
                    err_code_o <= 2'd0;
                    state      <= WR_SPM;
                end
                WR_SPM: if (xfer_done) begin
                    if (reg_error_i) begin
                        err_code_o <= ERR_BUS;
                        fin_err    <= 1'b1;
                        state      <= FIN;
                    end else begin
                        state <= flush_any ? WR_FLUSH : WR_COMMIT;
                    end
                end
                WR_FLUSH: if (xfer_done) begin
                    if (reg_error_i) begin
                        err_code_o <= ERR_BUS;
                        fin_err    <= 1'b1;
                        state      <= FIN;
                    end else begin
                        state <= WR_COMMIT;
                    end
                end
                WR_COMMIT: if (xfer_done) begin
                    if (reg_error_i) begin
                        err_code_o <= ERR_BUS;
                        fin_err    <= 1'b1;
                        state      <= FIN;
                    end else begin
                        state <= flush_any ? RD_STAT : FIN;
                    end
                end
                RD_STAT: if (xfer_done) begin
                    poll_cnt <= poll_inc;
                    if (reg_error_i) begin
                        err_code_o <= ERR_BUS;
                        fin_err    <= 1'b1;
                        state      <= FIN;
                    end else if (status_ok) begin
                        state <= FIN;
                    end else if (poll_inc == POLL_MAX_W) begin
                        err_code_o <= ERR_TIMEOUT;
                        fin_err    <= 1'b1;
                        state      <= FIN;
                    end else begin
                        gap_cnt <= GAP_LOAD;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == 8'd0) begin
                        state <= RD_STAT;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_llc_cfg_seq.sv
// Directed bench for axi_llc_cfg_seq: a RegBus slave model with programmable ready
// delay, read data and error injection logs every completed transfer for checking.
module tb_axi_llc_cfg_seq;

    localparam int GAP_CYC = 6;
    localparam int POLL_MX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  spm;
    logic [7:0]  flush;
    logic        busy, done, err;
    logic [1:0]  err_code;
    logic [31:0] reg_addr;
    logic        reg_write;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_wstrb;
    logic        reg_valid;
    logic [31:0] reg_rdata;
    logic        reg_error;
    logic        reg_ready;

    int checks = 0;
    int errors = 0;

    // Slave configuration, owned by the test tasks
    int          ready_delay = 0;
    int          rd_switch   = 0;
    logic [31:0] rd_first    = '0;
    logic [31:0] rd_later    = '0;
    bit          err_en      = 1'b0;
    logic [31:0] err_addr    = '0;

    // Slave state and transfer log, owned by the responder
    int          wait_cnt = 0;
    int          rd_idx   = 0;
    int          stab_err = 0;
    int          cyc      = 0;
    int          log_cnt  = 0;
    logic [68:0] log_tr  [64];
    int          log_cyc [64];
    logic [68:0] held_tr;

    axi_llc_cfg_seq #(
        .NumWays (8),
        .PollGap (GAP_CYC),
        .PollMax (POLL_MX)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .spm_mask_i   (spm),
        .flush_mask_i (flush),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .err_code_o   (err_code),
        .reg_addr_o   (reg_addr),
        .reg_write_o  (reg_write),
        .reg_wdata_o  (reg_wdata),
        .reg_wstrb_o  (reg_wstrb),
        .reg_valid_o  (reg_valid),
        .reg_rdata_i  (reg_rdata),
        .reg_error_i  (reg_error),
        .reg_ready_i  (reg_ready)
    );

    always #5 clk = ~clk;

    // Responder works on the falling edge: a ready raised here completes on the next rising edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        reg_ready = 1'b0;
        reg_error = 1'b0;
        reg_rdata = '0;
        if (rst || !reg_valid) begin
            wait_cnt = 0;
        end else begin
            if (wait_cnt == 0) held_tr = {reg_addr, reg_write, reg_wdata, reg_wstrb};
            else if ({reg_addr, reg_write, reg_wdata, reg_wstrb} !== held_tr) stab_err = stab_err + 1;
            if (wait_cnt < ready_delay) begin
                wait_cnt = wait_cnt + 1;
            end else begin
                wait_cnt  = 0;
                reg_ready = 1'b1;
                reg_error = err_en && (reg_addr == err_addr);
                if (!reg_write) begin
                    reg_rdata = (rd_idx < rd_switch) ? rd_first : rd_later;
                    rd_idx = rd_idx + 1;
                end
                if (log_cnt < 64) begin
                    log_tr[log_cnt]  = {reg_addr, reg_write, reg_wdata, reg_wstrb};
                    log_cyc[log_cnt] = cyc;
                end
                log_cnt = log_cnt + 1;
            end
        end
    end

    function automatic logic [68:0] tr(input logic [31:0] a, input logic w,
                                       input logic [31:0] d, input logic [3:0] s);
        return {a, w, d, s};
    endfunction

    function automatic logic [68:0] log_at(input int idx);
        if (idx < 0 || idx > 63) return '1;
        return log_tr[idx];
    endfunction

    task automatic kick(input logic [7:0] s, input logic [7:0] f);
        @(negedge clk);
        spm   = s;
        flush = f;
        start = 1'b1;
    endtask

    // Cycle 1 is the first cycle after the capture edge; masks are scrambled after capture.
    task automatic run_until_fin(input int max_cyc, input bit toggle, output int n_done,
                                 output int n_err, output int fin_cyc);
        n_done  = 0;
        n_err   = 0;
        fin_cyc = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge clk);
            start = (toggle && fin_cyc < 0) ? i[0] : 1'b0;
            if (i == 1) begin
                spm   = ~spm;
                flush = ~flush;
            end
            if (done) n_done++;
            if (err)  n_err++;
            if ((done || err) && fin_cyc < 0) begin
                fin_cyc = i;
                start   = 1'b0;
            end
            if (fin_cyc >= 0 && i >= fin_cyc + 4) break;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({busy, done, err, err_code, reg_valid} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_status: got %b expected 000000", {busy, done, err, err_code, reg_valid});
        end
        checks++;
        if ({reg_addr, reg_write, reg_wdata, reg_wstrb} !== 69'b0) begin
            errors++;
            $display("[TB] FAIL reset_request: got %h expected 0", {reg_addr, reg_write, reg_wdata, reg_wstrb});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_min_latency();
        int nd, ne, fc, base;
        logic [68:0] exp_tr [2];
        exp_tr[0] = tr(32'h00, 1'b1, 32'h0, 4'hF);
        exp_tr[1] = tr(32'h10, 1'b1, 32'h1, 4'hF);
        ready_delay = 0;
        base = log_cnt;
        kick(8'h00, 8'h00);
        run_until_fin(200, 1'b0, nd, ne, fc);
        checks++;
        if (fc + 1 !== 4) begin
            errors++;
            $display("[TB] FAIL min_latency: got %0d expected 4", fc + 1);
        end
        checks++;
        if (nd !== 1 || ne !== 0) begin
            errors++;
            $display("[TB] FAIL min_pulses: got done=%0d err=%0d expected done=1 err=0", nd, ne);
        end
        checks++;
        if (log_cnt - base !== 2) begin
            errors++;
            $display("[TB] FAIL min_xfer_count: got %0d expected 2", log_cnt - base);
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (log_at(base + k) !== exp_tr[k]) begin
                errors++;
                $display("[TB] FAIL min_xfer%0d: got %h expected %h", k, log_at(base + k), exp_tr[k]);
            end
        end
    endtask

    task automatic test_slow_ready_flush();
        int nd, ne, fc, base, sbase;
        logic [68:0] exp_tr [6];
        exp_tr[0] = tr(32'h00, 1'b1, 32'h0F, 4'hF);
        exp_tr[1] = tr(32'h08, 1'b1, 32'hF0, 4'hF);
        exp_tr[2] = tr(32'h10, 1'b1, 32'h01, 4'hF);
        for (int k = 3; k < 6; k++) exp_tr[k] = tr(32'h18, 1'b0, 32'h0, 4'h0);
        ready_delay = 3;
        rd_first    = 32'h30;
        rd_later    = 32'hF0;
        rd_switch   = rd_idx + 2;
        base  = log_cnt;
        sbase = stab_err;
        kick(8'h0F, 8'hF0);
        run_until_fin(300, 1'b0, nd, ne, fc);
        checks++;
        if (fc !== 37) begin
            errors++;
            $display("[TB] FAIL slow_fin_cycle: got %0d expected 37", fc);
        end
        checks++;
        if (nd !== 1 || ne !== 0) begin
            errors++;
            $display("[TB] FAIL slow_pulses: got done=%0d err=%0d expected done=1 err=0", nd, ne);
        end
        checks++;
        if (stab_err - sbase !== 0) begin
            errors++;
            $display("[TB] FAIL slow_req_stable: got %0d changes expected 0", stab_err - sbase);
        end
        checks++;
        if (log_cnt - base !== 6) begin
            errors++;
            $display("[TB] FAIL slow_xfer_count: got %0d expected 6", log_cnt - base);
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (log_at(base + k) !== exp_tr[k]) begin
                errors++;
                $display("[TB] FAIL slow_xfer%0d: got %h expected %h", k, log_at(base + k), exp_tr[k]);
            end
        end
        ready_delay = 0;
    endtask

    task automatic test_poll_timeout();
        int nd, ne, fc, base;
        rd_first  = 32'h70;
        rd_switch = rd_idx + 1000;
        base = log_cnt;
        kick(8'h00, 8'hF0);
        run_until_fin(300, 1'b0, nd, ne, fc);
        checks++;
        if (fc !== 26) begin
            errors++;
            $display("[TB] FAIL timeout_fin_cycle: got %0d expected 26", fc);
        end
        checks++;
        if (nd !== 0 || ne !== 1) begin
            errors++;
            $display("[TB] FAIL timeout_pulses: got done=%0d err=%0d expected done=0 err=1", nd, ne);
        end
        checks++;
        if (err_code !== 2'd2) begin
            errors++;
            $display("[TB] FAIL timeout_code: got %0d expected 2", err_code);
        end
        checks++;
        if (log_cnt - base !== 7) begin
            errors++;
            $display("[TB] FAIL timeout_xfer_count: got %0d expected 7", log_cnt - base);
        end
        for (int k = 4; k < 7; k++) begin
            checks++;
            if (log_cyc[base + k] - log_cyc[base + k - 1] !== GAP_CYC + 1) begin
                errors++;
                $display("[TB] FAIL timeout_read_spacing%0d: got %0d expected %0d", k,
                         log_cyc[base + k] - log_cyc[base + k - 1], GAP_CYC + 1);
            end
        end
        checks++;
        if (log_at(base + 6) !== tr(32'h18, 1'b0, 32'h0, 4'h0)) begin
            errors++;
            $display("[TB] FAIL timeout_last_read: got %h expected %h", log_at(base + 6), tr(32'h18, 1'b0, 32'h0, 4'h0));
        end
    endtask

    task automatic test_bus_error();
        int nd, ne, fc, base;
        err_en   = 1'b1;
        err_addr = 32'h08;
        base = log_cnt;
        kick(8'h01, 8'h02);
        run_until_fin(200, 1'b0, nd, ne, fc);
        err_en = 1'b0;
        checks++;
        if (fc !== 3 || nd !== 0 || ne !== 1) begin
            errors++;
            $display("[TB] FAIL buserr_pulses: got fin=%0d done=%0d err=%0d expected fin=3 done=0 err=1", fc, nd, ne);
        end
        checks++;
        if (err_code !== 2'd1) begin
            errors++;
            $display("[TB] FAIL buserr_code: got %0d expected 1", err_code);
        end
        checks++;
        if (log_cnt - base !== 2) begin
            errors++;
            $display("[TB] FAIL buserr_no_commit: got %0d transfers expected 2", log_cnt - base);
        end
        checks++;
        if (log_at(base + 1) !== tr(32'h08, 1'b1, 32'h02, 4'hF)) begin
            errors++;
            $display("[TB] FAIL buserr_flush_write: got %h expected %h", log_at(base + 1), tr(32'h08, 1'b1, 32'h02, 4'hF));
        end
    endtask

    task automatic test_start_while_busy();
        int nd, ne, fc, base;
        base = log_cnt;
        kick(8'h55, 8'h00);
        run_until_fin(200, 1'b1, nd, ne, fc);
        checks++;
        if (fc !== 3 || nd !== 1 || ne !== 0) begin
            errors++;
            $display("[TB] FAIL busy_start_pulses: got fin=%0d done=%0d err=%0d expected fin=3 done=1 err=0", fc, nd, ne);
        end
        checks++;
        if (log_cnt - base !== 2 || log_at(base) !== tr(32'h00, 1'b1, 32'h55, 4'hF)) begin
            errors++;
            $display("[TB] FAIL busy_start_xfers: got %0d first %h expected 2 first %h", log_cnt - base,
                     log_at(base), tr(32'h00, 1'b1, 32'h55, 4'hF));
        end
        checks++;
        if (busy !== 1'b0 || err_code !== 2'd0) begin
            errors++;
            $display("[TB] FAIL busy_start_end: got busy=%b code=%0d expected busy=0 code=0", busy, err_code);
        end
    endtask

    task automatic test_reset_in_gap();
        int nd, ne, fc, base;
        rd_first  = 32'h0;
        rd_switch = rd_idx + 1000;
        kick(8'h00, 8'h80);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || reg_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL gap_reached: got busy=%b valid=%b expected busy=1 valid=0", busy, reg_valid);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, err, err_code, reg_valid, reg_addr, reg_write, reg_wdata, reg_wstrb} !== 75'b0) begin
            errors++;
            $display("[TB] FAIL gap_async_reset: got %h expected 0",
                     {busy, done, err, err_code, reg_valid, reg_addr, reg_write, reg_wdata, reg_wstrb});
        end
        @(negedge clk);
        rst = 1'b0;
        base = log_cnt;
        kick(8'h03, 8'h00);
        run_until_fin(200, 1'b0, nd, ne, fc);
        checks++;
        if (fc !== 3 || nd !== 1 || ne !== 0) begin
            errors++;
            $display("[TB] FAIL after_reset_pulses: got fin=%0d done=%0d err=%0d expected fin=3 done=1 err=0", fc, nd, ne);
        end
        checks++;
        if (log_cnt - base !== 2 || log_at(base) !== tr(32'h00, 1'b1, 32'h03, 4'hF)
            || log_at(base + 1) !== tr(32'h10, 1'b1, 32'h01, 4'hF)) begin
            errors++;
            $display("[TB] FAIL after_reset_xfers: got %0d %h %h expected 2 %h %h", log_cnt - base,
                     log_at(base), log_at(base + 1), tr(32'h00, 1'b1, 32'h03, 4'hF), tr(32'h10, 1'b1, 32'h01, 4'hF));
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        spm   = '0;
        flush = '0;
        test_reset();
        test_min_latency();
        test_slow_ready_flush();
        test_poll_timeout();
        test_bus_error();
        test_start_while_busy();
        test_reset_in_gap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
